// File: rtl/ysyx_24110006_bus_pkg.sv
// Shared encodings for the core-side AXI4-lite arbiter: FSM states,
// response codes and requester ids.
package ysyx_24110006_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_IFU = 2'd1,
        RD_LSU = 2'd2,
        WR_LSU = 2'd3
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic IFU = 1'b0;
    localparam logic LSU = 1'b1;

endpackage

// File: rtl/ysyx_24110006_axi_arbiter.sv
// Two-master AXI4-lite arbiter (IFU read-only, LSU read/write) in front of
// the crossbar: one transaction at a time, writes first, reads round-robin.
module ysyx_24110006_axi_arbiter
    import ysyx_24110006_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = 8
) (
    input  logic              i_clock,
    input  logic              i_rst_n,

    input  logic [ADDR_W-1:0] i_ifu_araddr,
    input  logic              i_ifu_arvalid,
    output logic              o_ifu_arready,
    output logic [DATA_W-1:0] o_ifu_rdata,
    output logic [1:0]        o_ifu_rresp,
    output logic              o_ifu_rvalid,
    input  logic              i_ifu_rready,

    input  logic [ADDR_W-1:0] i_lsu_araddr,
    input  logic              i_lsu_arvalid,
    output logic              o_lsu_arready,
    output logic [DATA_W-1:0] o_lsu_rdata,
    output logic [1:0]        o_lsu_rresp,
    output logic              o_lsu_rvalid,
    input  logic              i_lsu_rready,
    input  logic [ADDR_W-1:0] i_lsu_awaddr,
    input  logic              i_lsu_awvalid,
    output logic              o_lsu_awready,
    input  logic [DATA_W-1:0] i_lsu_wdata,
    input  logic [STRB_W-1:0] i_lsu_wstrb,
    input  logic              i_lsu_wvalid,
    output logic              o_lsu_wready,
    output logic [1:0]        o_lsu_bresp,
    output logic              o_lsu_bvalid,
    input  logic              i_lsu_bready,

    output logic [ADDR_W-1:0] o_axi_araddr,
    output logic              o_axi_arvalid,
    input  logic              i_axi_arready,
    input  logic [DATA_W-1:0] i_axi_rdata,
    input  logic [1:0]        i_axi_rresp,
    input  logic              i_axi_rvalid,
    output logic              o_axi_rready,
    output logic [ADDR_W-1:0] o_axi_awaddr,
    output logic              o_axi_awvalid,
    input  logic              i_axi_awready,
    output logic [DATA_W-1:0] o_axi_wdata,
    output logic [STRB_W-1:0] o_axi_wstrb,
    output logic              o_axi_wvalid,
    input  logic              i_axi_wready,
    input  logic [1:0]        i_axi_bresp,
    input  logic              i_axi_bvalid,
    output logic              o_axi_bready
);

    state_e state_q;
    logic   ar_done_q;
    logic   aw_done_q;
    logic   w_done_q;
    logic   rr_last_q;

    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

    always_comb begin
        o_ifu_arready = 1'b0;
        o_ifu_rdata   = '0;
        o_ifu_rresp   = '0;
        o_ifu_rvalid  = 1'b0;
        o_lsu_arready = 1'b0;
        o_lsu_rdata   = '0;
        o_lsu_rresp   = '0;
        o_lsu_rvalid  = 1'b0;
        o_lsu_awready = 1'b0;
        o_lsu_wready  = 1'b0;
        o_lsu_bresp   = '0;
        o_lsu_bvalid  = 1'b0;
        o_axi_araddr  = '0;
        o_axi_arvalid = 1'b0;
        o_axi_rready  = 1'b0;
        o_axi_awaddr  = '0;
        o_axi_awvalid = 1'b0;
        o_axi_wdata   = '0;
        o_axi_wstrb   = '0;
        o_axi_wvalid  = 1'b0;
        o_axi_bready  = 1'b0;
        unique case (state_q)
            RD_IFU: begin
                o_axi_araddr  = i_ifu_araddr;
                o_axi_arvalid = i_ifu_arvalid & ~ar_done_q;
                o_ifu_arready = i_axi_arready & ~ar_done_q;
                o_ifu_rdata   = i_axi_rdata;
                o_ifu_rresp   = i_axi_rresp;
                o_ifu_rvalid  = i_axi_rvalid;
                o_axi_rready  = i_ifu_rready;
            end
            RD_LSU: begin
                o_axi_araddr  = i_lsu_araddr;
                o_axi_arvalid = i_lsu_arvalid & ~ar_done_q;
                o_lsu_arready = i_axi_arready & ~ar_done_q;
                o_lsu_rdata   = i_axi_rdata;
                o_lsu_rresp   = i_axi_rresp;
                o_lsu_rvalid  = i_axi_rvalid;
                o_axi_rready  = i_lsu_rready;
            end
            WR_LSU: begin
                o_axi_awaddr  = i_lsu_awaddr;
                o_axi_awvalid = i_lsu_awvalid & ~aw_done_q;
                o_lsu_awready = i_axi_awready & ~aw_done_q;
                o_axi_wdata   = i_lsu_wdata;
                o_axi_wstrb   = i_lsu_wstrb;
                o_axi_wvalid  = i_lsu_wvalid & ~w_done_q;
                o_lsu_wready  = i_axi_wready & ~w_done_q;
                o_lsu_bresp   = i_axi_bresp;
                o_lsu_bvalid  = i_axi_bvalid;
                o_axi_bready  = i_lsu_bready;
            end
            default: ;
        endcase
    end

    assign ar_hs = o_axi_arvalid & i_axi_arready;
    assign r_hs  = i_axi_rvalid  & o_axi_rready;
    assign aw_hs = o_axi_awvalid & i_axi_awready;
    assign w_hs  = o_axi_wvalid  & i_axi_wready;
    assign b_hs  = i_axi_bvalid  & o_axi_bready;

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            ar_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rr_last_q <= LSU;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_lsu_awvalid)
                        state_q <= WR_LSU;
                    else if (i_ifu_arvalid && i_lsu_arvalid)
                        state_q <= (rr_last_q == IFU) ? RD_LSU : RD_IFU;
                    else if (i_ifu_arvalid)
                        state_q <= RD_IFU;
                    else if (i_lsu_arvalid)
                        state_q <= RD_LSU;
                end
                RD_IFU, RD_LSU: begin
                    // R completion wins over a same-cycle AR handshake.
                    if (r_hs) begin
                        state_q   <= IDLE;
                        ar_done_q <= 1'b0;
                        rr_last_q <= (state_q == RD_LSU) ? LSU : IFU;
                    end else if (ar_hs) begin
                        ar_done_q <= 1'b1;
                    end
                end
                WR_LSU: begin
                    if (b_hs) begin
                        state_q   <= IDLE;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end else begin
                        if (aw_hs) aw_done_q <= 1'b1;
                        if (w_hs)  w_done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    // A granted master must hold its address valid until the handshake.
    always_ff @(posedge i_clock) begin
        if (i_rst_n) begin
            if (state_q == RD_IFU && !ar_done_q) assert (i_ifu_arvalid);
            if (state_q == RD_LSU && !ar_done_q) assert (i_lsu_arvalid);
            if (state_q == WR_LSU && !aw_done_q) assert (i_lsu_awvalid);
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_24110006_axi_arbiter.sv
// Randomized bench: agent-driven IFU/LSU masters and a memory-backed crossbar,
// checked each cycle against a transaction-level bus ownership model.
module tb_ysyx_24110006_axi_arbiter;
    import ysyx_24110006_bus_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 8;
    localparam int OWN_NONE = 0;
    localparam int OWN_IFU  = 1;
    localparam int OWN_LSUR = 2;
    localparam int OWN_LSUW = 3;
    localparam int unsigned N_CYC = 3000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [AW-1:0] ifu_araddr, lsu_araddr, lsu_awaddr;
    logic          ifu_arvalid, ifu_rready, lsu_arvalid, lsu_rready;
    logic          lsu_awvalid, lsu_wvalid, lsu_bready;
    logic [DW-1:0] lsu_wdata;
    logic [SW-1:0] lsu_wstrb;
    logic          ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid;
    logic          lsu_awready, lsu_wready, lsu_bvalid;
    logic [DW-1:0] ifu_rdata, lsu_rdata;
    logic [1:0]    ifu_rresp, lsu_rresp, lsu_bresp;

    logic [AW-1:0] axi_araddr, axi_awaddr;
    logic          axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready;
    logic [DW-1:0] axi_wdata;
    logic [SW-1:0] axi_wstrb;
    logic          s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
    logic [DW-1:0] s_rdata;
    logic [1:0]    s_rresp, s_bresp;

    ysyx_24110006_axi_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STRB_W(SW)) dut (
        .i_clock(clk), .i_rst_n(rst_n),
        .i_ifu_araddr(ifu_araddr), .i_ifu_arvalid(ifu_arvalid), .o_ifu_arready(ifu_arready),
        .o_ifu_rdata(ifu_rdata), .o_ifu_rresp(ifu_rresp), .o_ifu_rvalid(ifu_rvalid),
        .i_ifu_rready(ifu_rready),
        .i_lsu_araddr(lsu_araddr), .i_lsu_arvalid(lsu_arvalid), .o_lsu_arready(lsu_arready),
        .o_lsu_rdata(lsu_rdata), .o_lsu_rresp(lsu_rresp), .o_lsu_rvalid(lsu_rvalid),
        .i_lsu_rready(lsu_rready),
        .i_lsu_awaddr(lsu_awaddr), .i_lsu_awvalid(lsu_awvalid), .o_lsu_awready(lsu_awready),
        .i_lsu_wdata(lsu_wdata), .i_lsu_wstrb(lsu_wstrb), .i_lsu_wvalid(lsu_wvalid),
        .o_lsu_wready(lsu_wready),
        .o_lsu_bresp(lsu_bresp), .o_lsu_bvalid(lsu_bvalid), .i_lsu_bready(lsu_bready),
        .o_axi_araddr(axi_araddr), .o_axi_arvalid(axi_arvalid), .i_axi_arready(s_arready),
        .i_axi_rdata(s_rdata), .i_axi_rresp(s_rresp), .i_axi_rvalid(s_rvalid),
        .o_axi_rready(axi_rready),
        .o_axi_awaddr(axi_awaddr), .o_axi_awvalid(axi_awvalid), .i_axi_awready(s_awready),
        .o_axi_wdata(axi_wdata), .o_axi_wstrb(axi_wstrb), .o_axi_wvalid(axi_wvalid),
        .i_axi_wready(s_wready),
        .i_axi_bresp(s_bresp), .i_axi_bvalid(s_bvalid), .o_axi_bready(axi_bready)
    );

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Crossbar-side memory: unwritten words read back a hash of the address.
    logic [DW-1:0] mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'h5ee0_1234);
    endfunction

    function automatic logic [1:0] resp_of(input logic [AW-1:0] a);
        return (a[31:28] == 4'hf) ? RESP_SLVERR : RESP_OKAY;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] b;
        case ($urandom_range(0, 3))
            0:       b = 32'h3000_0000;
            1:       b = 32'h8000_0000;
            2:       b = 32'ha000_03f0;
            default: b = 32'hf000_0000;
        endcase
        return b + ($urandom_range(0, 3) << 2);
    endfunction

    // Bus ownership model
    int   owner;
    logic last_lsu;
    logic ar_sent, aw_sent, w_sent;

    // Master agents
    int            ifu_st, lsu_st;
    logic [AW-1:0] ifu_addr, lsu_addr;
    logic [DW-1:0] lsu_wd;
    logic [SW-1:0] lsu_ws;
    logic          aw_pend, w_pend, w_go, force_tie;

    // Crossbar agent
    logic          sr_busy, sw_aw, sw_w;
    int            sr_dly, sw_dly;
    logic [AW-1:0] sr_addr, sw_addr;
    logic [DW-1:0] sw_data;

    // Expected DUT outputs
    logic [AW-1:0] e_axi_araddr, e_axi_awaddr;
    logic          e_axi_arvalid, e_axi_rready, e_axi_awvalid, e_axi_wvalid, e_axi_bready;
    logic [DW-1:0] e_axi_wdata, e_ifu_rdata, e_lsu_rdata;
    logic [SW-1:0] e_axi_wstrb;
    logic          e_ifu_arready, e_ifu_rvalid, e_lsu_arready, e_lsu_rvalid;
    logic          e_lsu_awready, e_lsu_wready, e_lsu_bvalid;
    logic [1:0]    e_ifu_rresp, e_lsu_rresp, e_lsu_bresp;

    task automatic clear_all();
        owner = OWN_NONE; last_lsu = 1'b1;
        ar_sent = 1'b0; aw_sent = 1'b0; w_sent = 1'b0;
        ifu_st = 0; lsu_st = 0; aw_pend = 1'b0; w_pend = 1'b0; w_go = 1'b0;
        sr_busy = 1'b0; sw_aw = 1'b0; sw_w = 1'b0; sr_dly = 0; sw_dly = 0;
        ifu_arvalid = 1'b0; ifu_rready = 1'b0; ifu_araddr = '0;
        lsu_arvalid = 1'b0; lsu_rready = 1'b0; lsu_araddr = '0;
        lsu_awvalid = 1'b0; lsu_awaddr = '0; lsu_wvalid = 1'b0; lsu_wdata = '0;
        lsu_wstrb = '0; lsu_bready = 1'b0;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
        s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = '0;
        force_tie = 1'b1;
    endtask

    task automatic drive();
        if (ifu_st == 0 && (force_tie || $urandom_range(0, 2) == 0)) begin
            ifu_st = 1; ifu_addr = rand_addr();
        end
        if (lsu_st == 0 && (force_tie || $urandom_range(0, 2) == 0)) begin
            lsu_addr = rand_addr();
            if (!force_tie && $urandom_range(0, 1) == 1) begin
                lsu_st = 3; lsu_wd = $urandom; lsu_ws = 8'($urandom);
                aw_pend = 1'b1; w_pend = 1'b1; w_go = 1'b0;
            end else begin
                lsu_st = 1;
            end
        end
        force_tie = 1'b0;
        if (w_pend && !w_go && $urandom_range(0, 1) == 1) w_go = 1'b1;

        ifu_arvalid = (ifu_st == 1);
        ifu_araddr  = (ifu_st != 0) ? ifu_addr : $urandom;
        ifu_rready  = ($urandom_range(0, 3) != 0);
        lsu_arvalid = (lsu_st == 1);
        lsu_araddr  = (lsu_st == 1 || lsu_st == 2) ? lsu_addr : $urandom;
        lsu_rready  = ($urandom_range(0, 3) != 0);
        lsu_awvalid = (lsu_st == 3) && aw_pend;
        lsu_awaddr  = (lsu_st == 3) ? lsu_addr : $urandom;
        lsu_wvalid  = (lsu_st == 3) && w_pend && w_go;
        lsu_wdata   = (lsu_st == 3) ? lsu_wd : $urandom;
        lsu_wstrb   = (lsu_st == 3) ? lsu_ws : 8'($urandom);
        lsu_bready  = ($urandom_range(0, 3) != 0);

        s_arready = ($urandom_range(0, 1) == 1);
        s_rvalid  = sr_busy && sr_dly == 0;
        s_rdata   = s_rvalid ? rd_val(sr_addr) : $urandom;
        s_rresp   = s_rvalid ? resp_of(sr_addr) : 2'($urandom);
        s_awready = ($urandom_range(0, 1) == 1);
        s_wready  = ($urandom_range(0, 1) == 1);
        s_bvalid  = sw_aw && sw_w && sw_dly == 0;
        s_bresp   = s_bvalid ? resp_of(sw_addr) : 2'($urandom);
    endtask

    // Whoever owns the bus sees the crossbar; everybody else sees zeros.
    task automatic compute_exp();
        e_axi_araddr = '0; e_axi_arvalid = 1'b0; e_axi_rready = 1'b0;
        e_axi_awaddr = '0; e_axi_awvalid = 1'b0; e_axi_wdata = '0; e_axi_wstrb = '0;
        e_axi_wvalid = 1'b0; e_axi_bready = 1'b0;
        e_ifu_arready = 1'b0; e_ifu_rvalid = 1'b0; e_ifu_rdata = '0; e_ifu_rresp = '0;
        e_lsu_arready = 1'b0; e_lsu_rvalid = 1'b0; e_lsu_rdata = '0; e_lsu_rresp = '0;
        e_lsu_awready = 1'b0; e_lsu_wready = 1'b0; e_lsu_bvalid = 1'b0; e_lsu_bresp = '0;
        if (owner == OWN_IFU) begin
            e_axi_araddr = ifu_araddr; e_axi_arvalid = ifu_arvalid && !ar_sent;
            e_ifu_arready = s_arready && !ar_sent;
            e_ifu_rvalid = s_rvalid; e_ifu_rdata = s_rdata; e_ifu_rresp = s_rresp;
            e_axi_rready = ifu_rready;
        end else if (owner == OWN_LSUR) begin
            e_axi_araddr = lsu_araddr; e_axi_arvalid = lsu_arvalid && !ar_sent;
            e_lsu_arready = s_arready && !ar_sent;
            e_lsu_rvalid = s_rvalid; e_lsu_rdata = s_rdata; e_lsu_rresp = s_rresp;
            e_axi_rready = lsu_rready;
        end else if (owner == OWN_LSUW) begin
            e_axi_awaddr = lsu_awaddr; e_axi_awvalid = lsu_awvalid && !aw_sent;
            e_lsu_awready = s_awready && !aw_sent;
            e_axi_wdata = lsu_wdata; e_axi_wstrb = lsu_wstrb;
            e_axi_wvalid = lsu_wvalid && !w_sent; e_lsu_wready = s_wready && !w_sent;
            e_lsu_bvalid = s_bvalid; e_lsu_bresp = s_bresp; e_axi_bready = lsu_bready;
        end
    endtask

    task automatic check_outputs(input string pfx);
        chk({pfx, "axi"},
            128'({axi_araddr, axi_arvalid, axi_rready, axi_awaddr, axi_awvalid,
                  axi_wdata, axi_wstrb, axi_wvalid, axi_bready}),
            128'({e_axi_araddr, e_axi_arvalid, e_axi_rready, e_axi_awaddr, e_axi_awvalid,
                  e_axi_wdata, e_axi_wstrb, e_axi_wvalid, e_axi_bready}));
        chk({pfx, "ifu"},
            128'({ifu_arready, ifu_rvalid, ifu_rdata, ifu_rresp}),
            128'({e_ifu_arready, e_ifu_rvalid, e_ifu_rdata, e_ifu_rresp}));
        chk({pfx, "lsu"},
            128'({lsu_arready, lsu_rvalid, lsu_rdata, lsu_rresp, lsu_awready,
                  lsu_wready, lsu_bvalid, lsu_bresp}),
            128'({e_lsu_arready, e_lsu_rvalid, e_lsu_rdata, e_lsu_rresp, e_lsu_awready,
                  e_lsu_wready, e_lsu_bvalid, e_lsu_bresp}));
    endtask

    task automatic update();
        logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
        ar_hs = e_axi_arvalid && s_arready;
        r_hs  = s_rvalid && e_axi_rready;
        aw_hs = e_axi_awvalid && s_awready;
        w_hs  = e_axi_wvalid && s_wready;
        b_hs  = s_bvalid && e_axi_bready;

        if (owner == OWN_IFU) begin
            if (ar_hs) ifu_st = 2;
            if (r_hs) begin
                chk("ifu_rd", 128'({ifu_rresp, ifu_rdata}),
                    128'({resp_of(ifu_addr), rd_val(ifu_addr)}));
                ifu_st = 0;
            end
        end else if (owner == OWN_LSUR) begin
            if (ar_hs) lsu_st = 2;
            if (r_hs) begin
                chk("lsu_rd", 128'({lsu_rresp, lsu_rdata}),
                    128'({resp_of(lsu_addr), rd_val(lsu_addr)}));
                lsu_st = 0;
            end
        end else if (owner == OWN_LSUW) begin
            if (aw_hs) aw_pend = 1'b0;
            if (w_hs) begin w_pend = 1'b0; w_go = 1'b0; end
            if (b_hs) begin
                chk("lsu_b", 128'(lsu_bresp), 128'(resp_of(lsu_addr)));
                lsu_st = 0;
            end
        end

        if (ar_hs) begin
            sr_busy = 1'b1; sr_addr = axi_araddr; sr_dly = $urandom_range(0, 3);
        end else if (sr_busy && sr_dly > 0) begin
            sr_dly--;
        end
        if (r_hs) sr_busy = 1'b0;
        if (aw_hs) begin sw_aw = 1'b1; sw_addr = axi_awaddr; sw_dly = $urandom_range(0, 2); end
        if (w_hs)  begin sw_w = 1'b1; sw_data = axi_wdata; end
        if (!aw_hs && !w_hs && sw_aw && sw_w && sw_dly > 0) sw_dly--;
        if (b_hs) begin mem[sw_addr] = sw_data; sw_aw = 1'b0; sw_w = 1'b0; end

        case (owner)
            OWN_NONE: begin
                if (lsu_awvalid)                     owner = OWN_LSUW;
                else if (ifu_arvalid && lsu_arvalid) owner = last_lsu ? OWN_IFU : OWN_LSUR;
                else if (ifu_arvalid)                owner = OWN_IFU;
                else if (lsu_arvalid)                owner = OWN_LSUR;
            end
            OWN_IFU, OWN_LSUR: begin
                if (r_hs) begin
                    last_lsu = (owner == OWN_LSUR);
                    owner = OWN_NONE; ar_sent = 1'b0;
                end else if (ar_hs) begin
                    ar_sent = 1'b1;
                end
            end
            default: begin
                if (b_hs) begin
                    owner = OWN_NONE; aw_sent = 1'b0; w_sent = 1'b0;
                end else begin
                    if (aw_hs) aw_sent = 1'b1;
                    if (w_hs)  w_sent  = 1'b1;
                end
            end
        endcase
    endtask

    // Asynchronous reset mid-cycle: outputs must drop at once, inputs still active.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        owner = OWN_NONE;
        compute_exp();
        check_outputs("rst_");
        clear_all();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        bit special_done;
        special_done = 1'b0;
        rst_n = 1'b1;
        clear_all();
        #2;
        do_reset();
        for (int unsigned cyc = 0; cyc < N_CYC; cyc++) begin
            @(posedge clk);
            #1;
            drive();
            #1;
            compute_exp();
            check_outputs("");
            if ((!special_done && owner == OWN_LSUR && ar_sent) || (cyc % 700 == 699)) begin
                if (owner == OWN_LSUR && ar_sent) special_done = 1'b1;
                #1;
                do_reset();
            end else begin
                update();
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
